// File: rtl/inert_pkg.sv
// Shared definitions for the inertial sensor interface: FSM state
// encodings, the sensor command words, the offsets and gains used by
// the pitch integrator, and small arithmetic helpers.
// Build option: define INERT_FUSION_EN to enable accelerometer fusion.
package inert_pkg;

  // Top-level sequencing states
  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    WAIT_INT,
    RD_RTL,
    RD_RTH,
    RD_AZL,
    RD_AZH,
    UPDATE,
    PULSE
  } state_t;

  // SPI master states
  typedef enum logic {
    SPI_IDLE,
    SPI_BUSY
  } spi_state_t;

  // Sensor configuration writes, issued once after power-up
  localparam logic [15:0] CMD_INIT1 = 16'h0D02;
  localparam logic [15:0] CMD_INIT2 = 16'h1053;
  localparam logic [15:0] CMD_INIT3 = 16'h1150;
  localparam logic [15:0] CMD_INIT4 = 16'h1460;

  // Read commands: the address is in the upper byte, data returns in the lower
  localparam logic [15:0] RD_RTL_CMD = 16'hA200;
  localparam logic [15:0] RD_RTH_CMD = 16'hA300;
  localparam logic [15:0] RD_AZL_CMD = 16'hAC00;
  localparam logic [15:0] RD_AZH_CMD = 16'hAD00;

  // Integrator and fusion constants
  localparam logic [15:0] PTCH_RT_OFFSET = 16'h0050;
  localparam logic [15:0] AZ_OFFSET      = 16'h00A0;
  localparam logic [25:0] FUSION_GAIN    = 26'd327;
  localparam logic [26:0] FUSION_STEP    = 27'd1024;

  // Sign-extend a 16-bit value to the integrator width
  function automatic logic [26:0] sext16_27(input logic [15:0] v);
    return {{11{v[15]}}, v};
  endfunction

  // Pitch estimate derived from the accelerometer Z reading
  function automatic logic [12:0] calc_ptch_acc(input logic [15:0] az);
    logic [15:0]        az_off;
    logic signed [25:0] prod;
    az_off = az - AZ_OFFSET;
    prod   = $signed({{10{az_off[15]}}, az_off}) * $signed(FUSION_GAIN);
    return 13'(prod >>> 13);
  endfunction

endpackage

// File: rtl/inert_intf_spi.sv
// spi_mnrch: 16-bit SPI master, mode 3 (SCLK idles high, MOSI launched on
// the falling edge, MISO captured on the rising edge), SCLK = clk/16,
// MSB first. A write request while busy is ignored; done pulses for one
// clock when the last bit has been captured, with rd_data complete.
module spi_mnrch
  import inert_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  spi_state_t  r_state;
  logic [3:0]  r_div;
  logic [3:0]  r_bits;
  logic [15:0] r_shft;
  logic        r_ss_n;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_done;

  // Shift engine: divider phase 7 drops SCLK and launches the next bit,
  // phase 15 raises SCLK and captures MISO into the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SPI_IDLE;
      r_div   <= 4'd0;
      r_bits  <= 4'd0;
      r_shft  <= 16'h0000;
      r_ss_n  <= 1'b1;
      r_sclk  <= 1'b1;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SPI_IDLE: begin
          if (wrt) begin
            r_state <= SPI_BUSY;
            r_ss_n  <= 1'b0;
            r_div   <= 4'd0;
            r_bits  <= 4'd0;
            r_shft  <= wt_data;
          end else begin
            r_sclk  <= 1'b1;
          end
        end
        SPI_BUSY: begin
          r_div <= r_div + 4'd1;
          if (r_div == 4'd7) begin
            r_sclk <= 1'b0;
            r_mosi <= r_shft[15];
          end else if (r_div == 4'd15) begin
            r_sclk <= 1'b1;
            r_shft <= {r_shft[14:0], MISO};
            if (r_bits == 4'd15) begin
              r_state <= SPI_IDLE;
              r_ss_n  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_bits  <= r_bits + 4'd1;
            end
          end else begin
            r_sclk <= r_sclk;
          end
        end
        default: begin
          r_state <= SPI_IDLE;
          r_ss_n  <= 1'b1;
          r_sclk  <= 1'b1;
        end
      endcase
    end
  end

  assign done    = r_done;
  assign rd_data = r_shft;
  assign SS_n    = r_ss_n;
  assign SCLK    = r_sclk;
  assign MOSI    = r_mosi;

endmodule

// File: rtl/inert_intf.sv
// inert_intf: sequences an inertial sensor over SPI. After a power-up
// wait it writes four configuration words, then on each data-ready
// interrupt reads pitch rate (L/H) and accelerometer Z (L/H), integrates
// the offset-compensated rate into a 27-bit pitch accumulator and pulses
// vld with the new pitch and raw rate.
// Build option: define INERT_FUSION_EN to nudge the integrator toward the
// accelerometer-derived pitch each sample. The AZ reads happen in both
// builds so the SPI traffic is identical.
module inert_intf
  import inert_pkg::*;
#(
  parameter int fast_sim = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        vld,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt
);

  state_t      r_state;
  logic [15:0] r_timer;
  logic        r_wrt;
  logic [15:0] r_cmd;
  logic        r_int_ff1;
  logic        r_int_ff2;
  logic [7:0]  r_rtl;
  logic [7:0]  r_rth;
  logic [7:0]  r_azl;
  logic [7:0]  r_azh;
  logic [26:0] r_ptch_int;
  logic [15:0] r_ptch_rt;
  logic        r_vld;

  logic        w_done;
  logic [15:0] w_rd_data;
  logic        w_timer_done;
  logic [15:0] w_rt_comp;
  logic [26:0] w_fus;
  logic [26:0] w_ptch_int_nxt;
  logic        w_unused;

  spi_mnrch u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (r_wrt),
    .wt_data (r_cmd),
    .done    (w_done),
    .rd_data (w_rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // Power-up wait terminal count: 2^9 clocks for simulation, 2^16 otherwise
  assign w_timer_done = (fast_sim != 0) ? (r_timer[8:0] == 9'h1FF)
                                        : (r_timer == 16'hFFFF);

  // Offset-compensated rate of the sample being committed
  assign w_rt_comp = {r_rth, r_rtl} - PTCH_RT_OFFSET;

`ifdef INERT_FUSION_EN
  logic [12:0] w_ptch_acc;

  // Fusion term steers the accumulator toward the accelerometer pitch
  always_comb begin
    w_ptch_acc = calc_ptch_acc({r_azh, r_azl});
    if ($signed({{3{w_ptch_acc[12]}}, w_ptch_acc}) > $signed(r_ptch_int[26:11])) begin
      w_fus = FUSION_STEP;
    end else begin
      w_fus = ~FUSION_STEP + 27'd1;
    end
  end

  assign w_unused = ^w_rd_data[15:8];
`else
  assign w_fus    = 27'd0;
  assign w_unused = ^{w_rd_data[15:8], r_azl, r_azh};
`endif

  // One integrator step; wraps two's-complement
  assign w_ptch_int_nxt = r_ptch_int - sext16_27(w_rt_comp) + w_fus;

  // Two-flop synchronizer for the asynchronous data-ready interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
    end else begin
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
    end
  end

  // Main sequencer: power-up wait, init writes, interrupt-driven read burst,
  // integrator update and valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PWR_WAIT;
      r_timer    <= 16'h0000;
      r_wrt      <= 1'b0;
      r_cmd      <= 16'h0000;
      r_rtl      <= 8'h00;
      r_rth      <= 8'h00;
      r_azl      <= 8'h00;
      r_azh      <= 8'h00;
      r_ptch_int <= 27'd0;
      r_ptch_rt  <= 16'h0000;
      r_vld      <= 1'b0;
    end else begin
      r_wrt <= 1'b0;
      r_vld <= 1'b0;
      case (r_state)
        PWR_WAIT: begin
          if (w_timer_done) begin
            r_state <= INIT1;
            r_timer <= 16'h0000;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_INIT1;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        INIT1: begin
          if (w_done) begin
            r_state <= INIT2;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_INIT2;
          end
        end
        INIT2: begin
          if (w_done) begin
            r_state <= INIT3;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_INIT3;
          end
        end
        INIT3: begin
          if (w_done) begin
            r_state <= INIT4;
            r_wrt   <= 1'b1;
            r_cmd   <= CMD_INIT4;
          end
        end
        INIT4: begin
          if (w_done) begin
            r_state <= WAIT_INT;
          end
        end
        WAIT_INT: begin
          if (r_int_ff2) begin
            r_state <= RD_RTL;
            r_wrt   <= 1'b1;
            r_cmd   <= RD_RTL_CMD;
          end
        end
        RD_RTL: begin
          if (w_done) begin
            r_rtl   <= w_rd_data[7:0];
            r_state <= RD_RTH;
            r_wrt   <= 1'b1;
            r_cmd   <= RD_RTH_CMD;
          end
        end
        RD_RTH: begin
          if (w_done) begin
            r_rth   <= w_rd_data[7:0];
            r_state <= RD_AZL;
            r_wrt   <= 1'b1;
            r_cmd   <= RD_AZL_CMD;
          end
        end
        RD_AZL: begin
          if (w_done) begin
            r_azl   <= w_rd_data[7:0];
            r_state <= RD_AZH;
            r_wrt   <= 1'b1;
            r_cmd   <= RD_AZH_CMD;
          end
        end
        RD_AZH: begin
          if (w_done) begin
            r_azh   <= w_rd_data[7:0];
            r_state <= UPDATE;
          end
        end
        UPDATE: begin
          r_ptch_rt  <= {r_rth, r_rtl};
          r_ptch_int <= w_ptch_int_nxt;
          r_vld      <= 1'b1;
          r_state    <= PULSE;
        end
        PULSE: begin
          r_state <= WAIT_INT;
        end
        default: begin
          r_state <= PWR_WAIT;
          r_timer <= 16'h0000;
        end
      endcase
    end
  end

  assign vld     = r_vld;
  assign ptch    = r_ptch_int[26:11];
  assign ptch_rt = r_ptch_rt;

endmodule
